tx_handshake_probe: RTL and testbench

- Initiator (TX-domain) end of the tx_started req/ack four-phase handshake, with round-trip measurement added.
- Monitors a TX AXI-Stream (observe only, never drives tvalid/tready) and detects the first accepted beat of each packet.
- On each detected packet start, runs one req/ack four-phase cycle toward the RX side and measures req-to-ack round-trip in clk cycles.
- Reports the result, or a timeout, as a one-cycle pulse. Used in timing test harnesses next to bit-sync chains.

---
 rtl/tx_probe_pkg.sv | 28 ++
 rtl/tx_handshake_probe_if.sv | 29 ++
 rtl/axis_sof_detect.sv | 37 +++
 rtl/tx_handshake_probe.sv | 147 ++++++++++++++
 tb/tb_tx_handshake_probe.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tx_probe_pkg.sv
// Shared types and helpers for the tx_started handshake probe.
//   state_t  : handshake FSM state encoding (2-bit)
//   sat_inc  : increment that saturates at 2**w-1, for counters up to SAT_W bits
package tx_probe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    localparam int unsigned SAT_W = 32;

    // Width is passed as an argument so one function serves every counter;
    // callers zero-extend into and truncate out of the SAT_W-bit carrier.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input int unsigned       w);
        logic [SAT_W:0] one_w;
        logic [SAT_W:0] lim;
        one_w = {{SAT_W{1'b0}}, 1'b1};
        lim   = (one_w << w) - one_w;
        if ({1'b0, v} >= lim) begin
            return v;
        end
        return v + one_w[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/tx_handshake_probe_if.sv
// Bundle of the monitored TX AXI-Stream handshake and the tx_started
// req/ack pair.
//   master : probe side (observes the stream and ack, drives req)
//   slave  : environment side (drives the stream and ack, observes req)
interface tx_handshake_probe_if;

    logic axis_tvalid;
    logic axis_tready;
    logic axis_tlast;
    logic tx_started_req;
    logic tx_started_ack;

    modport master (
        input  axis_tvalid,
        input  axis_tready,
        input  axis_tlast,
        input  tx_started_ack,
        output tx_started_req
    );

    modport slave (
        output axis_tvalid,
        output axis_tready,
        output axis_tlast,
        output tx_started_ack,
        input  tx_started_req
    );

endinterface

// File: rtl/axis_sof_detect.sv
// Start-of-frame detector for an observed AXI-Stream.
//   clk, areset : clock, async active-high reset
//   tvalid, tready, tlast : monitored stream handshake
//   sof         : combinational, high on the first accepted beat of a packet
// in_pkt tracks whether a packet is open; a single-beat packet leaves it clear.
module axis_sof_detect (
    input  logic clk,
    input  logic areset,
    input  logic tvalid,
    input  logic tready,
    input  logic tlast,
    output logic sof
);

    logic beat;
    logic in_pkt_d;
    logic in_pkt_q;

    always_comb begin
        beat     = tvalid & tready;
        in_pkt_d = in_pkt_q;
        if (beat) begin
            in_pkt_d = ~tlast;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            in_pkt_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
        end
    end

    assign sof = beat & ~in_pkt_q;

endmodule

// File: rtl/tx_handshake_probe.sv
// Initiator end of the tx_started four-phase handshake with round-trip
// measurement. Each packet start seen on the TX stream launches one req/ack
// cycle; the req-to-ack delay in clk cycles is reported, or a timeout.
//   clk, areset  : clock, async active-high reset
//   hs           : stream monitor inputs, ack input, req output (master)
//   rtt_valid    : 1-cycle pulse, rtt_cycles updated
//   rtt_cycles   : last round trip, held until the next update
//   timeout_err  : 1-cycle pulse when REQ_HI gives up waiting for ack
//   busy         : high whenever the FSM is not IDLE
// Optional build macro TX_HANDSHAKE_PROBE_STATS_EN adds saturating
// probe_count / skip_count outputs.
//
// state  | meaning
// IDLE   | waiting for a packet start with ack low
// REQ_HI | req asserted, counting cycles until ack or timeout
// REQ_LO | req released, waiting for ack to return low
module tx_handshake_probe
    import tx_probe_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    areset,
    tx_handshake_probe_if.master    hs,
    output logic                    rtt_valid,
    output logic [CNT_WIDTH-1:0]    rtt_cycles,
    output logic                    timeout_err,
`ifdef TX_HANDSHAKE_PROBE_STATS_EN
    output logic [15:0]             probe_count,
    output logic [15:0]             skip_count,
`endif
    output logic                    busy
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    state_t                 state_q;
    logic                   req_q;
    logic                   busy_q;
    logic                   rtt_valid_q;
    logic                   timeout_err_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   rtt_cycles_q;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   sof;
    logic                   ack;

    assign ack     = hs.tx_started_ack;
    assign cnt_inc = CNT_WIDTH'(sat_inc(SAT_W'(cnt_q), CNT_WIDTH));

    axis_sof_detect u_sof (
        .clk    (clk),
        .areset (areset),
        .tvalid (hs.axis_tvalid),
        .tready (hs.axis_tready),
        .tlast  (hs.axis_tlast),
        .sof    (sof)
    );

`ifdef TX_HANDSHAKE_PROBE_STATS_EN
    logic [15:0] probe_count_q;
    logic [15:0] skip_count_q;
    logic [15:0] probe_inc;
    logic [15:0] skip_inc;
    assign probe_inc = 16'(sat_inc(SAT_W'(probe_count_q), 16));
    assign skip_inc  = 16'(sat_inc(SAT_W'(skip_count_q), 16));
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
            rtt_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            rtt_cycles_q  <= '0;
`ifdef TX_HANDSHAKE_PROBE_STATS_EN
            probe_count_q <= '0;
            skip_count_q  <= '0;
`endif
        end else begin
            rtt_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A stale ack would complete the handshake instantly,
                    // so the probe is skipped rather than launched.
                    if (sof && !ack) begin
                        state_q <= REQ_HI;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                REQ_HI: begin
                    // cnt_inc is the number of req-high edges seen so far,
                    // including this one.
                    if (ack) begin
                        rtt_cycles_q <= cnt_inc;
                        rtt_valid_q  <= 1'b1;
                        req_q        <= 1'b0;
                        state_q      <= REQ_LO;
                    end else if (cnt_inc == TIMEOUT_C) begin
                        timeout_err_q <= 1'b1;
                        req_q         <= 1'b0;
                        state_q       <= REQ_LO;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                REQ_LO: begin
                    if (!ack) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
`ifdef TX_HANDSHAKE_PROBE_STATS_EN
            if (sof) begin
                if (state_q == IDLE && !ack) begin
                    probe_count_q <= probe_inc;
                end else begin
                    skip_count_q <= skip_inc;
                end
            end
`endif
        end
    end

    assign hs.tx_started_req = req_q;
    assign busy              = busy_q;
    assign rtt_valid         = rtt_valid_q;
    assign timeout_err       = timeout_err_q;
    assign rtt_cycles        = rtt_cycles_q;
`ifdef TX_HANDSHAKE_PROBE_STATS_EN
    assign probe_count = probe_count_q;
    assign skip_count  = skip_count_q;
`endif

endmodule

// File: tb/tb_tx_handshake_probe.sv
// Directed bench for tx_handshake_probe (TIMEOUT=16). Stats outputs are
// checked only when TX_HANDSHAKE_PROBE_STATS_EN is defined.
module tb_tx_handshake_probe;

    logic        clk;
    logic        areset;
    logic        rtt_valid;
    logic [15:0] rtt_cycles;
    logic        timeout_err;
    logic        busy;
`ifdef TX_HANDSHAKE_PROBE_STATS_EN
    logic [15:0] probe_count;
    logic [15:0] skip_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    tx_handshake_probe_if hs_if ();

    tx_handshake_probe #(
        .CNT_WIDTH (16),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .hs          (hs_if),
        .rtt_valid   (rtt_valid),
        .rtt_cycles  (rtt_cycles),
        .timeout_err (timeout_err),
`ifdef TX_HANDSHAKE_PROBE_STATS_EN
        .probe_count (probe_count),
        .skip_count  (skip_count),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_beat(input logic v, input logic last);
        hs_if.axis_tvalid = v;
        hs_if.axis_tready = v;
        hs_if.axis_tlast  = last;
    endtask

    task automatic do_reset(input logic ack_val);
        areset = 1'b1;
        set_beat(1'b0, 1'b0);
        hs_if.tx_started_ack = ack_val;
        ticks(2);
        areset = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input int probes, input int skips);
`ifdef TX_HANDSHAKE_PROBE_STATS_EN
        chk({tag, "_probe"}, 32'(probe_count), probes);
        chk({tag, "_skip"},  32'(skip_count),  skips);
`else
        if (tag.len() < 0) $display("%0d %0d", probes, skips);
`endif
    endtask

    initial begin
        areset = 1'b1;
        set_beat(1'b0, 1'b0);
        hs_if.tx_started_ack = 1'b0;
        #2;
        chk("async_rst_req", 32'(hs_if.tx_started_req), 0);

        // 1: reset state, 4-beat packet, rtt = 10
        do_reset(1'b0);
        chk("rst_req",  32'(hs_if.tx_started_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv",   32'(rtt_valid), 0);
        chk("rst_to",   32'(timeout_err), 0);
        chk("rst_rtt",  32'(rtt_cycles), 0);
        chk_stats("rst", 0, 0);
        set_beat(1'b1, 1'b0); tick();                 // E0: sof
        chk("t1_req_up",  32'(hs_if.tx_started_req), 1);
        chk("t1_busy_up", 32'(busy), 1);
        set_beat(1'b1, 1'b0); tick();                 // E1
        set_beat(1'b1, 1'b0); tick();                 // E2
        set_beat(1'b1, 1'b1); tick();                 // E3: last beat
        set_beat(1'b0, 1'b0); ticks(6);               // E9
        chk("t1_req_e9", 32'(hs_if.tx_started_req), 1);
        chk("t1_rv_e9",  32'(rtt_valid), 0);
        hs_if.tx_started_ack = 1'b1; tick();          // E10
        chk("t1_rv",     32'(rtt_valid), 1);
        chk("t1_rtt",    32'(rtt_cycles), 10);
        chk("t1_req_dn", 32'(hs_if.tx_started_req), 0);
        chk("t1_busy",   32'(busy), 1);
        tick();                                       // E11
        chk("t1_rv_pulse", 32'(rtt_valid), 0);
        tick();                                       // E12
        chk("t1_busy_lo_wait", 32'(busy), 1);
        hs_if.tx_started_ack = 1'b0; tick();          // E13
        chk("t1_busy_dn", 32'(busy), 0);
        chk("t1_rtt_hold", 32'(rtt_cycles), 10);

        // 2: timeout after 16 req-high edges, then ack on edge 16 wins
        do_reset(1'b0);
        set_beat(1'b1, 1'b1); tick();
        set_beat(1'b0, 1'b0); ticks(15);
        chk("t2_to_early", 32'(timeout_err), 0);
        chk("t2_req_e15",  32'(hs_if.tx_started_req), 1);
        tick();
        chk("t2_to",       32'(timeout_err), 1);
        chk("t2_req_dn",   32'(hs_if.tx_started_req), 0);
        chk("t2_rtt_keep", 32'(rtt_cycles), 0);
        chk("t2_rv_none",  32'(rtt_valid), 0);
        tick();
        chk("t2_to_pulse", 32'(timeout_err), 0);
        chk("t2_idle",     32'(busy), 0);
        set_beat(1'b1, 1'b1); tick();
        set_beat(1'b0, 1'b0); ticks(15);
        hs_if.tx_started_ack = 1'b1; tick();
        chk("t2b_rv",  32'(rtt_valid), 1);
        chk("t2b_rtt", 32'(rtt_cycles), 16);
        chk("t2b_to",  32'(timeout_err), 0);
        hs_if.tx_started_ack = 1'b0; tick();
        chk("t2b_idle", 32'(busy), 0);

        // 3: sof during REQ_HI ignored, next packet handshakes
        do_reset(1'b0);
        set_beat(1'b1, 1'b0); tick();                 // E0: packet A
        set_beat(1'b1, 1'b1); tick();                 // E1: A ends
        set_beat(1'b1, 1'b1); tick();                 // E2: packet B, skipped
        set_beat(1'b0, 1'b0);
        hs_if.tx_started_ack = 1'b1; tick();          // E3
        chk("t3_rv",  32'(rtt_valid), 1);
        chk("t3_rtt", 32'(rtt_cycles), 3);
        hs_if.tx_started_ack = 1'b0; tick();
        chk("t3_idle", 32'(busy), 0);
        set_beat(1'b1, 1'b1); tick();                 // packet C
        chk("t3_req_c", 32'(hs_if.tx_started_req), 1);
        set_beat(1'b0, 1'b0);
        hs_if.tx_started_ack = 1'b1; tick();
        chk("t3_rtt1", 32'(rtt_cycles), 1);
        hs_if.tx_started_ack = 1'b0; tick();
        chk("t3_idle2", 32'(busy), 0);
        chk_stats("t3", 2, 1);

        // 4: back-to-back single-beat packets
        do_reset(1'b0);
        set_beat(1'b1, 1'b1); tick();                 // E0
        chk("t4_req0", 32'(hs_if.tx_started_req), 1);
        hs_if.tx_started_ack = 1'b1; tick();          // E1
        chk("t4_rtt", 32'(rtt_cycles), 1);
        chk("t4_req1", 32'(hs_if.tx_started_req), 0);
        tick();                                       // E2
        hs_if.tx_started_ack = 1'b0; tick();          // E3
        chk("t4_busy3", 32'(busy), 0);
        chk("t4_req3",  32'(hs_if.tx_started_req), 0);
        tick();                                       // E4
        chk("t4_req4", 32'(hs_if.tx_started_req), 1);
        set_beat(1'b0, 1'b0);
        hs_if.tx_started_ack = 1'b1; tick();
        chk("t4_rv5", 32'(rtt_valid), 1);
        hs_if.tx_started_ack = 1'b0; tick();
        chk("t4_idle", 32'(busy), 0);
        chk_stats("t4", 2, 3);

        // 5: ack high across reset release, sof skipped
        do_reset(1'b1);
        set_beat(1'b1, 1'b1); tick();
        chk("t5_no_req",  32'(hs_if.tx_started_req), 0);
        chk("t5_no_busy", 32'(busy), 0);
        set_beat(1'b0, 1'b0);
        hs_if.tx_started_ack = 1'b0; tick();
        set_beat(1'b1, 1'b1); tick();
        chk("t5_req", 32'(hs_if.tx_started_req), 1);
        set_beat(1'b0, 1'b0); tick();
        hs_if.tx_started_ack = 1'b1; tick();
        chk("t5_rtt", 32'(rtt_cycles), 2);
        hs_if.tx_started_ack = 1'b0; tick();
        chk_stats("t5", 1, 1);

        // 6: areset in REQ_HI at cnt=5 discards the measurement
        set_beat(1'b1, 1'b1); tick();
        set_beat(1'b0, 1'b0); ticks(5);
        #2 areset = 1'b1;
        #1;
        chk("t6_req",  32'(hs_if.tx_started_req), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rtt",  32'(rtt_cycles), 0);
        tick();
        areset = 1'b0;
        tick();
        chk("t6_no_rv", 32'(rtt_valid), 0);
        chk("t6_no_to", 32'(timeout_err), 0);
        set_beat(1'b1, 1'b1); tick();
        set_beat(1'b0, 1'b0); ticks(3);
        hs_if.tx_started_ack = 1'b1; tick();
        chk("t6_rv",  32'(rtt_valid), 1);
        chk("t6_rtt4", 32'(rtt_cycles), 4);
        hs_if.tx_started_ack = 1'b0; tick();
        chk("t6_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
